// File: rtl/bram_pl_sequencer.sv
// Preload/readback controller for a QL_BRAM chain: runs the PL_INIT pulse train,
// then arbitrates single-word PL accesses between the config loader and debug readback.
//
// state | meaning
// IDLE  | waiting for the first start_init_i after reset
// INIT  | pl_init_o held high for INIT_CYCLES cycles
// ARB   | round-robin grant between the two requesters
// ISSUE | one-cycle PL strobe for the accepted access
// WAIT  | read in flight, waiting RD_LAT cycles for chain-tail data
module bram_pl_sequencer #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 36,
  parameter int INIT_CYCLES = 4,
  parameter int RD_LAT      = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_init_i,
  output logic                  init_done_o,
  output logic                  busy_o,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [1:0]            req_we_i,
  input  logic [2*ADDR_W-1:0]   req_addr_i,
  input  logic [2*DATA_W-1:0]   req_wdata_i,
  input  logic [3:0]            req_wen_i,
  output logic [1:0]            rsp_valid_o,
  output logic [DATA_W-1:0]     rsp_rdata_o,
  output logic                  pl_init_o,
  output logic                  pl_ena_o,
  output logic                  pl_ren_o,
  output logic [1:0]            pl_wen_o,
  output logic [ADDR_W-1:0]     pl_addr_o,
  output logic [DATA_W-1:0]     pl_data_o,
  input  logic [DATA_W-1:0]     pl_data_i
);

  localparam int CNT_MAX = (INIT_CYCLES > RD_LAT) ? INIT_CYCLES : RD_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INIT_LOAD = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ARB   = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rr_q, rr_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic                init_done_q, init_done_d;
  logic                busy_q, busy_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                pl_init_q, pl_init_d;
  logic                pl_ena_q, pl_ena_d;
  logic                pl_ren_q, pl_ren_d;
  logic [1:0]          pl_wen_q, pl_wen_d;
  logic [ADDR_W-1:0]   pl_addr_q, pl_addr_d;
  logic [DATA_W-1:0]   pl_data_q, pl_data_d;

  logic grant;
  logic accept;

  // A start_init_i in ARB masks ready so the init request wins over a pending access.
  always_comb begin
    if (req_valid_i[0] && req_valid_i[1]) grant = rr_q;
    else                                  grant = req_valid_i[1];
    accept      = (state_q == S_ARB) && !start_init_i && (req_valid_i != 2'b00);
    req_ready_o = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    we_d        = we_q;
    init_done_d = init_done_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = '0;
    pl_init_d   = 1'b0;
    pl_ena_d    = 1'b0;
    pl_ren_d    = 1'b0;
    pl_wen_d    = 2'b00;
    pl_addr_d   = pl_addr_q;
    pl_data_d   = pl_data_q;

    case (state_q)
      S_IDLE: begin
        if (start_init_i) begin
          state_d     = S_INIT;
          cnt_d       = INIT_LOAD;
          pl_init_d   = 1'b1;
          init_done_d = 1'b0;
        end
      end
      S_INIT: begin
        if (cnt_q == '0) begin
          state_d     = S_ARB;
          init_done_d = 1'b1;
        end else begin
          cnt_d     = cnt_q - 1'b1;
          pl_init_d = 1'b1;
        end
      end
      S_ARB: begin
        if (accept) begin
          state_d   = S_ISSUE;
          owner_d   = grant;
          rr_d      = ~grant;
          we_d      = grant ? req_we_i[1] : req_we_i[0];
          pl_ena_d  = 1'b1;
          pl_addr_d = grant ? req_addr_i[2*ADDR_W-1:ADDR_W] : req_addr_i[ADDR_W-1:0];
          if (we_d) begin
            pl_wen_d  = grant ? req_wen_i[3:2] : req_wen_i[1:0];
            pl_data_d = grant ? req_wdata_i[2*DATA_W-1:DATA_W] : req_wdata_i[DATA_W-1:0];
          end else begin
            pl_ren_d = 1'b1;
          end
        end else if (start_init_i) begin
          state_d     = S_INIT;
          cnt_d       = INIT_LOAD;
          pl_init_d   = 1'b1;
          init_done_d = 1'b0;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d     = S_ARB;
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        end else begin
          state_d = S_WAIT;
          cnt_d   = RD_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = S_ARB;
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          rsp_rdata_d = pl_data_i;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_INIT) || (state_d == S_ISSUE) || (state_d == S_WAIT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rr_q        <= 1'b0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      pl_init_q   <= 1'b0;
      pl_ena_q    <= 1'b0;
      pl_ren_q    <= 1'b0;
      pl_wen_q    <= 2'b00;
      pl_addr_q   <= '0;
      pl_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      pl_init_q   <= pl_init_d;
      pl_ena_q    <= pl_ena_d;
      pl_ren_q    <= pl_ren_d;
      pl_wen_q    <= pl_wen_d;
      pl_addr_q   <= pl_addr_d;
      pl_data_q   <= pl_data_d;
    end
  end

  assign init_done_o = init_done_q;
  assign busy_o      = busy_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign pl_init_o   = pl_init_q;
  assign pl_ena_o    = pl_ena_q;
  assign pl_ren_o    = pl_ren_q;
  assign pl_wen_o    = pl_wen_q;
  assign pl_addr_o   = pl_addr_q;
  assign pl_data_o   = pl_data_q;

endmodule

// File: tb/tb_bram_pl_sequencer.sv
// Bench for bram_pl_sequencer: directed init/write/read/reset scenarios plus randomized
// two-requester traffic checked against a transaction-level round-robin model.
module tb_bram_pl_sequencer;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 36;
  localparam int INIT_CYCLES = 4;
  localparam int RD_LAT      = 2;

  logic                clock = 1'b0;
  logic                reset;
  logic                start_init_i;
  logic                init_done_o;
  logic                busy_o;
  logic [1:0]          req_valid_i;
  logic [1:0]          req_ready_o;
  logic [1:0]          req_we_i;
  logic [2*ADDR_W-1:0] req_addr_i;
  logic [2*DATA_W-1:0] req_wdata_i;
  logic [3:0]          req_wen_i;
  logic [1:0]          rsp_valid_o;
  logic [DATA_W-1:0]   rsp_rdata_o;
  logic                pl_init_o;
  logic                pl_ena_o;
  logic                pl_ren_o;
  logic [1:0]          pl_wen_o;
  logic [ADDR_W-1:0]   pl_addr_o;
  logic [DATA_W-1:0]   pl_data_o;
  logic [DATA_W-1:0]   pl_data_i;

  bram_pl_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_CYCLES(INIT_CYCLES), .RD_LAT(RD_LAT)
  ) dut (
    .clock(clock), .reset(reset), .start_init_i(start_init_i),
    .init_done_o(init_done_o), .busy_o(busy_o),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wen_i(req_wen_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .pl_init_o(pl_init_o), .pl_ena_o(pl_ena_o), .pl_ren_o(pl_ren_o),
    .pl_wen_o(pl_wen_o), .pl_addr_o(pl_addr_o), .pl_data_o(pl_data_o),
    .pl_data_i(pl_data_i)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Pending request per requester (held until accepted) and the data the chain returns for reads.
  logic              pend_v     [2];
  logic              pend_we    [2];
  logic [ADDR_W-1:0] pend_addr  [2];
  logic [DATA_W-1:0] pend_wdata [2];
  logic [1:0]        pend_wen   [2];
  logic [DATA_W-1:0] pend_rdata [2];
  int                rr_next;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DATA_W-1:0];
  endfunction

  task automatic drive_reqs();
    req_valid_i = {pend_v[1], pend_v[0]};
    req_we_i    = {pend_we[1], pend_we[0]};
    req_addr_i  = {pend_addr[1], pend_addr[0]};
    req_wdata_i = {pend_wdata[1], pend_wdata[0]};
    req_wen_i   = {pend_wen[1], pend_wen[0]};
  endtask

  task automatic set_req(input int r, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [1:0] wen,
                         input logic [DATA_W-1:0] rd);
    pend_v[r] = 1'b1; pend_we[r] = we; pend_addr[r] = a;
    pend_wdata[r] = d; pend_wen[r] = wen; pend_rdata[r] = rd;
  endtask

  task automatic rand_req(input int r);
    set_req(r, 1'($urandom_range(0, 1)), $urandom, rnd_data(), 2'($urandom_range(0, 3)), rnd_data());
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {53'd0, init_done_o, busy_o, req_ready_o, rsp_valid_o,
                        pl_init_o, pl_ena_o, pl_ren_o, pl_wen_o}, 64'd0);
    chk({tag, "_addr"}, 64'(pl_addr_o), 64'd0);
    chk({tag, "_data"}, 64'(pl_data_o), 64'd0);
    chk({tag, "_rdata"}, 64'(rsp_rdata_o), 64'd0);
  endtask

  // Pulse start_init_i and follow the init sequence to the first ARB cycle.
  task automatic run_init();
    int n;
    start_init_i = 1'b1;
    #1;
    chk("init_req_rdy", 64'(req_ready_o), 64'd0);
    tick();
    start_init_i = 1'b0;
    n = 0;
    for (int i = 0; i < INIT_CYCLES + 10; i++) begin
      if (init_done_o) break;
      if (pl_init_o) n++;
      chk("init_rdy", 64'(req_ready_o), 64'd0);
      chk("init_busy", 64'(busy_o), 64'd1);
      tick();
    end
    chk("init_len", 64'(n), 64'(INIT_CYCLES));
    chk("init_done", 64'(init_done_o), 64'd1);
    chk("init_pl_low", 64'(pl_init_o), 64'd0);
    chk("init_idle_busy", 64'(busy_o), 64'd0);
  endtask

  // Serve one access in an ARB cycle: check grant, the PL strobe and the completion timing.
  task automatic serve(output int got_g);
    int g;
    logic we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d, rd;
    logic [1:0] wen;
    drive_reqs();
    #1;
    g = (pend_v[0] && pend_v[1]) ? rr_next : (pend_v[1] ? 1 : 0);
    chk("grant", 64'(req_ready_o), (g == 1) ? 64'd2 : 64'd1);
    got_g = req_ready_o[1] ? 1 : 0;
    we = pend_we[g]; a = pend_addr[g]; d = pend_wdata[g]; wen = pend_wen[g]; rd = pend_rdata[g];
    tick();
    pend_v[g] = 1'b0;
    rr_next = 1 - g;
    drive_reqs();
    pl_data_i = rnd_data();
    chk("iss_ena", 64'(pl_ena_o), 64'd1);
    chk("iss_addr", 64'(pl_addr_o), 64'(a));
    chk("iss_ren", 64'(pl_ren_o), 64'(!we));
    chk("iss_wen", 64'(pl_wen_o), we ? 64'(wen) : 64'd0);
    if (we) chk("iss_data", 64'(pl_data_o), 64'(d));
    chk("iss_busy", 64'(busy_o), 64'd1);
    chk("iss_rdy", 64'(req_ready_o), 64'd0);
    if (!we) begin
      for (int j = 1; j <= RD_LAT; j++) begin
        tick();
        pl_data_i = (j == RD_LAT) ? rd : rnd_data();
        chk("wait_rsp", 64'(rsp_valid_o), 64'd0);
        chk("wait_ena", 64'(pl_ena_o | pl_ren_o), 64'd0);
      end
    end
    tick();
    pl_data_i = rnd_data();
    chk("rsp_valid", 64'(rsp_valid_o), (g == 1) ? 64'd2 : 64'd1);
    chk("rsp_rdata", 64'(rsp_rdata_o), we ? 64'd0 : 64'(rd));
    chk("rsp_busy", 64'(busy_o), 64'd0);
  endtask

  initial begin
    int g;
    int exp_order [4];
    exp_order = '{0, 1, 0, 1};
    reset = 1'b1;
    start_init_i = 1'b0;
    pl_data_i = '0;
    rr_next = 0;
    for (int r = 0; r < 2; r++) set_req(r, 1'b0, '0, '0, 2'b00, '0);
    pend_v[0] = 1'b0; pend_v[1] = 1'b0;
    drive_reqs();
    tick(); tick();
    reset = 1'b0;
    tick();
    chk_zero("reset");

    run_init();

    set_req(0, 1'b1, 32'h0003_0010, 36'h9_ABCD_1234, 2'b11, '0);
    serve(g);
    set_req(1, 1'b0, 32'h0001_0004, '0, 2'b00, 36'h1_2345_6789);
    serve(g);

    rand_req(0); pend_we[0] = 1'b1;
    rand_req(1); pend_we[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      serve(g);
      chk("rr_order", 64'(g), 64'(exp_order[k]));
      if (k < 2) begin
        rand_req(g);
        pend_we[g] = 1'b1;
      end
    end

    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < 2; r++)
        if (!pend_v[r] && ($urandom_range(0, 1) == 1)) rand_req(r);
      if (!pend_v[0] && !pend_v[1]) rand_req($urandom_range(0, 1));
      serve(g);
    end
    for (int k = 0; k < 2 && (pend_v[0] || pend_v[1]); k++) serve(g);

    set_req(0, 1'b0, 32'hBEEF_0042, '0, 2'b00, 36'hA_5A5A_0F0F);
    drive_reqs();
    #1;
    chk("rst_mid_grant", 64'(req_ready_o), 64'd1);
    tick();
    pend_v[0] = 1'b0;
    drive_reqs();
    chk("rst_mid_ren", 64'(pl_ren_o), 64'd1);
    tick();
    reset = 1'b1;
    #1;
    chk_zero("rst_mid");
    pl_data_i = 36'hA_5A5A_0F0F;
    tick();
    chk("rst_hold_rsp", 64'(rsp_valid_o), 64'd0);
    tick();
    chk("rst_hold_rsp2", 64'(rsp_valid_o), 64'd0);
    reset = 1'b0;
    rr_next = 0;
    tick();
    chk("rst_after_rsp", 64'(rsp_valid_o), 64'd0);
    chk("rst_after_done", 64'(init_done_o), 64'd0);
    run_init();
    set_req(0, 1'b0, 32'hBEEF_0042, '0, 2'b00, 36'hA_5A5A_0F0F);
    serve(g);

    set_req(0, 1'b1, 32'h0007_0100, rnd_data(), 2'b01, '0);
    drive_reqs();
    run_init();
    serve(g);
    chk("reinit_grant", 64'(g), 64'd0);

    set_req(1, 1'b1, 32'h0002_0003, rnd_data(), 2'b00, '0);
    serve(g);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
